env_adsr: RTL and testbench

ADSR envelope generator that sits directly upstream of the noise (and other) oscillators, driving their signed 17-bit `volume` port. One envelope step is computed per `clk` edge; `clk` is the 44.1 kHz audio sample clock, so rates are in level units per sample. Note-on/note-off arrive as a level-sensitive `gate`, and the block produces a registered, glitch-free volume level.

---
 rtl/env_adsr.sv | 135 +++++++++++++
 tb/tb_env_adsr.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/env_adsr.sv
// env_adsr
// ADSR envelope generator that drives the signed volume input of a downstream
// oscillator. One envelope step is taken per rising edge of the audio sample
// clock, so every rate is expressed in level units per sample.
//
// Ports:
//   clk            audio sample clock; all state advances on its rising edge
//   rst            asynchronous, active-high reset
//   gate           note held (1) / released (0), level-sensitive
//   peak           attack target level (unsigned)
//   attack_rate    per-sample increment in ATTACK, 0 = jump straight to peak
//   decay_rate     per-sample decrement in DECAY, 0 = jump straight to sustain
//   sustain_level  hold level; the effective sustain is min(sustain_level, peak)
//   release_rate   per-sample decrement in RELEASE, 0 = jump straight to zero
//   volume         {1'b0, level}, registered, always non-negative
//   state          IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   active         high whenever state is not IDLE (registered)

module env_adsr #(
  parameter int PEAK_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gate,
  input  logic [PEAK_W-1:0]        peak,
  input  logic [PEAK_W-1:0]        attack_rate,
  input  logic [PEAK_W-1:0]        decay_rate,
  input  logic [PEAK_W-1:0]        sustain_level,
  input  logic [PEAK_W-1:0]        release_rate,
  output logic signed [PEAK_W:0]   volume,
  output logic [2:0]               state,
  output logic                     active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t              state_q;
  state_t              next_state;
  logic [PEAK_W-1:0]   level;
  logic [PEAK_W-1:0]   next_level;
  logic                gate_q;
  logic                rise;
  logic [PEAK_W-1:0]   eff_sustain;
  logic [PEAK_W:0]     attack_sum;
  logic [PEAK_W:0]     decay_limit;

  // Only the rising edge of gate needs detecting; a low gate is acted on
  // directly as a level.
  assign rise = gate & ~gate_q;

  // Sustain can never sit above the peak the attack climbed to.
  assign eff_sustain = (sustain_level < peak) ? sustain_level : peak;

  // One extra bit on both the attack sum and the decay threshold so neither
  // can wrap; the compares below then saturate the level cleanly.
  assign attack_sum  = {1'b0, level} + {1'b0, attack_rate};
  assign decay_limit = {1'b0, eff_sustain} + {1'b0, decay_rate};

  // State and level register. The level and the phase change are written on
  // the same edge, so the volume never shows an unclamped intermediate value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level   <= '0;
      gate_q  <= 1'b0;
      active  <= 1'b0;
    end else begin
      state_q <= next_state;
      level   <= next_level;
      gate_q  <= gate;
      active  <= (next_state != IDLE);
    end
  end

  // Next-state and next-level logic. A retrigger keeps the current level so
  // a note restarted mid-release climbs from where it is instead of clicking
  // down to zero first.
  always_comb begin
    next_state = state_q;
    next_level = level;
    if (rise) begin
      next_state = ATTACK;
    end else if (!gate && (state_q == ATTACK || state_q == DECAY ||
                           state_q == SUSTAIN)) begin
      next_state = RELEASE;
    end else begin
      case (state_q)
        IDLE: begin
          next_level = '0;
        end
        ATTACK: begin
          if (attack_rate == '0 || attack_sum >= {1'b0, peak}) begin
            next_level = peak;
            next_state = DECAY;
          end else begin
            next_level = attack_sum[PEAK_W-1:0];
          end
        end
        DECAY: begin
          if (decay_rate == '0 || {1'b0, level} <= decay_limit) begin
            next_level = eff_sustain;
            next_state = SUSTAIN;
          end else begin
            next_level = level - decay_rate;
          end
        end
        SUSTAIN: begin
          next_level = eff_sustain;
        end
        RELEASE: begin
          if (release_rate == '0 || level <= release_rate) begin
            next_level = '0;
            next_state = IDLE;
          end else begin
            next_level = level - release_rate;
          end
        end
        default: begin
          next_level = '0;
          next_state = IDLE;
        end
      endcase
    end
  end

  assign volume = {1'b0, level};
  assign state  = state_q;

endmodule

// File: tb/tb_env_adsr.sv
// tb_env_adsr
// Self-checking bench for env_adsr. Each task drives one scenario with
// directed inputs and compares volume/state/active against hand-computed
// values, sampling on the falling edge of clk.

module tb_env_adsr;

  logic               clk;
  logic               rst;
  logic               gate;
  logic [15:0]        peak;
  logic [15:0]        attack_rate;
  logic [15:0]        decay_rate;
  logic [15:0]        sustain_level;
  logic [15:0]        release_rate;
  logic signed [16:0] volume;
  logic [2:0]         state;
  logic               active;

  int num_checks;
  int num_failures;

  env_adsr #(.PEAK_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .gate          (gate),
    .peak          (peak),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .volume        (volume),
    .state         (state),
    .active        (active)
  );

  // 10 time-unit sample clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic signed [16:0] ev;
    rst = 1'b1;
    gate = 1'b0;
    peak = 16'd1000;
    attack_rate = 16'd300;
    decay_rate = 16'd100;
    sustain_level = 16'd700;
    release_rate = 16'd50;
    #1;
    ev = 17'sd0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      num_checks++;
      if (volume !== ev) begin
        num_failures++;
        $display("[TB] FAIL reset_volume[%0d] got=%0d want=0", i, volume);
      end
      num_checks++;
      if (state !== 3'd0) begin
        num_failures++;
        $display("[TB] FAIL reset_state[%0d] got=%0d want=0", i, state);
      end
      num_checks++;
      if (active !== 1'b0) begin
        num_failures++;
        $display("[TB] FAIL reset_active[%0d] got=%b want=0", i, active);
      end
    end
    rst = 1'b0;
    tick();
    num_checks++;
    if (state !== 3'd0 || volume !== ev) begin
      num_failures++;
      $display("[TB] FAIL idle_after_reset got state=%0d vol=%0d want state=0 vol=0", state, volume);
    end
  endtask

  task automatic test_full_envelope();
    int exp_vol [8] = '{0, 300, 600, 900, 1000, 900, 800, 700};
    int exp_st  [8] = '{1, 1, 1, 1, 2, 2, 2, 3};
    logic signed [16:0] ev;
    gate = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      ev = 17'(exp_vol[i]);
      num_checks++;
      if (volume !== ev || state !== 3'(exp_st[i]) || active !== 1'b1) begin
        num_failures++;
        $display("[TB] FAIL envelope[%0d] got vol=%0d st=%0d act=%b want vol=%0d st=%0d act=1",
                 i, volume, state, active, exp_vol[i], exp_st[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      num_checks++;
      if (volume !== 17'sd700 || state !== 3'd3) begin
        num_failures++;
        $display("[TB] FAIL sustain_hold[%0d] got vol=%0d st=%0d want vol=700 st=3", i, volume, state);
      end
    end
    // Live sustain and peak changes are tracked on the next edge.
    sustain_level = 16'd500;
    tick();
    num_checks++;
    if (volume !== 17'sd500) begin
      num_failures++;
      $display("[TB] FAIL sustain_live got=%0d want=500", volume);
    end
    sustain_level = 16'd700;
    peak = 16'd600;
    tick();
    num_checks++;
    if (volume !== 17'sd600) begin
      num_failures++;
      $display("[TB] FAIL sustain_peak_clamp got=%0d want=600", volume);
    end
    peak = 16'd1000;
    tick();
    num_checks++;
    if (volume !== 17'sd700 || state !== 3'd3) begin
      num_failures++;
      $display("[TB] FAIL sustain_restore got vol=%0d st=%0d want vol=700 st=3", volume, state);
    end
  endtask

  task automatic test_release();
    int ev_int;
    int es;
    logic signed [16:0] ev;
    gate = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      ev_int = (k < 15) ? (700 - 50 * (k - 1)) : 0;
      es = (k < 15) ? 4 : 0;
      ev = 17'(ev_int);
      num_checks++;
      if (volume !== ev || state !== 3'(es) || active !== (k < 15)) begin
        num_failures++;
        $display("[TB] FAIL release[%0d] got vol=%0d st=%0d act=%b want vol=%0d st=%0d act=%b",
                 k, volume, state, active, ev_int, es, (k < 15));
      end
    end
  endtask

  task automatic test_retrigger();
    int exp_vol [3] = '{400, 700, 1000};
    int exp_st  [3] = '{1, 1, 2};
    logic signed [16:0] ev;
    gate = 1'b1;
    repeat (8) tick();
    gate = 1'b0;
    repeat (7) tick();
    num_checks++;
    if (volume !== 17'sd400 || state !== 3'd4) begin
      num_failures++;
      $display("[TB] FAIL retrig_setup got vol=%0d st=%0d want vol=400 st=4", volume, state);
    end
    gate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ev = 17'(exp_vol[i]);
      num_checks++;
      if (volume !== ev || state !== 3'(exp_st[i])) begin
        num_failures++;
        $display("[TB] FAIL retrigger[%0d] got vol=%0d st=%0d want vol=%0d st=%0d",
                 i, volume, state, exp_vol[i], exp_st[i]);
      end
    end
  endtask

  task automatic test_zero_rates();
    int exp_vol [5] = '{0, 1000, 1000, 1000, 0};
    int exp_st  [5] = '{1, 2, 3, 4, 0};
    logic signed [16:0] ev;
    attack_rate = 16'd0;
    decay_rate = 16'd0;
    release_rate = 16'd0;
    sustain_level = 16'd2000;
    gate = 1'b0;
    repeat (2) tick();
    num_checks++;
    if (volume !== 17'sd0 || state !== 3'd0) begin
      num_failures++;
      $display("[TB] FAIL zero_setup got vol=%0d st=%0d want vol=0 st=0", volume, state);
    end
    gate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) gate = 1'b0;
      tick();
      ev = 17'(exp_vol[i]);
      num_checks++;
      if (volume !== ev || state !== 3'(exp_st[i])) begin
        num_failures++;
        $display("[TB] FAIL zero_rates[%0d] got vol=%0d st=%0d want vol=%0d st=%0d",
                 i, volume, state, exp_vol[i], exp_st[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_vol [3] = '{0, 40000, 65535};
    int exp_st  [3] = '{1, 1, 2};
    logic signed [16:0] ev;
    peak = 16'd65535;
    attack_rate = 16'd40000;
    sustain_level = 16'd30000;
    gate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ev = 17'(exp_vol[i]);
      num_checks++;
      if (volume !== ev || state !== 3'(exp_st[i])) begin
        num_failures++;
        $display("[TB] FAIL saturate[%0d] got vol=%0d st=%0d want vol=%0d st=%0d",
                 i, volume, state, exp_vol[i], exp_st[i]);
      end
    end
    gate = 1'b0;
    repeat (2) tick();
    gate = 1'b1;
    repeat (2) tick();
    num_checks++;
    if (volume !== 17'sd40000 || state !== 3'd1) begin
      num_failures++;
      $display("[TB] FAIL mid_attack_setup got vol=%0d st=%0d want vol=40000 st=1", volume, state);
    end
    // Assert reset between clock edges; outputs must clear with no edge.
    #2 rst = 1'b1;
    #1;
    num_checks++;
    if (volume !== 17'sd0 || state !== 3'd0 || active !== 1'b0) begin
      num_failures++;
      $display("[TB] FAIL async_reset got vol=%0d st=%0d act=%b want vol=0 st=0 act=0", volume, state, active);
    end
    @(negedge clk);
  endtask

  task automatic test_gate_from_reset();
    peak = 16'd1000;
    attack_rate = 16'd300;
    gate = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    num_checks++;
    if (volume !== 17'sd0 || state !== 3'd1 || active !== 1'b1) begin
      num_failures++;
      $display("[TB] FAIL gate_from_reset got vol=%0d st=%0d act=%b want vol=0 st=1 act=1", volume, state, active);
    end
    tick();
    num_checks++;
    if (volume !== 17'sd300 || state !== 3'd1) begin
      num_failures++;
      $display("[TB] FAIL gate_from_reset_step got vol=%0d st=%0d want vol=300 st=1", volume, state);
    end
  endtask

  initial begin
    num_checks = 0;
    num_failures = 0;
    test_reset();
    test_full_envelope();
    test_release();
    test_retrigger();
    test_zero_rates();
    test_saturation();
    test_gate_from_reset();
    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
